// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input operand select with a registered
// output and a 2-entry skid buffer on a valid/ready handshake.
module mux_n_pipe #(
  parameter int              WIDTH     = 32,
  parameter int              N_IN      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             SEL_W     = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  localparam entry_t RST_E = '{
    data: RESET_VAL,
    sel:  '0,
    err:  1'b0
  };

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t nxt;
  logic   accept;
  logic   drain;

  // Out-of-range codes fall through to RESET_VAL with err set
  always_comb begin
    nxt.data = RESET_VAL;
    nxt.sel  = sel;
    nxt.err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if ({1'b0, sel} == (SEL_W+1)'(k)) begin
        nxt.data = in_data[k*WIDTH +: WIDTH];
        nxt.err  = 1'b0;
      end
    end
  end

  assign in_ready  = (state != TWO) & ~reset;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q.data;
  assign out_sel   = main_q.sel;
  assign out_err   = main_q.err;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= RST_E;
      skid_q <= RST_E;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= nxt;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= nxt;
          end else if (accept) begin
            skid_q <= nxt;
            state  <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-input, WIDTH-bit operand select stage with a registered output and a valid/ready handshake. It generalises the 2:1 combinational select used in the datapath: it selects one of N_IN packed inputs and registers the result with its select code. A 2-entry skid buffer gives full throughput without a combinational ready path. It sits between the operand-forwarding logic and the EX stage, where the pipeline needs stall and flush support.

## Interface
- WIDTH, 32, bit width of each data input and of out_data
- N_IN, 4, number of selectable inputs, 2..16
- SEL_W, $clog2(N_IN), select width; derived, not overridden
- RESET_VAL, 0, value of out_data after reset and for an out-of-range select
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  binary select, sampled with in_data on accept
- in_valid  in  1  upstream offers in_data/sel this cycle
- in_ready  out  1  stage can accept this cycle
- flush  in  1  discard all buffered entries
- out_data  out  WIDTH  selected word of the head entry
- out_sel  out  SEL_W  select code captured with the head entry
- out_err  out  1  head entry had sel >= N_IN
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes the head entry this cycle

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Each entry stores the selected word, sel and err. The selected word is in_data[sel*WIDTH +: WIDTH] if sel < N_IN. Otherwise it is RESET_VAL with err=1.
- Storage is a main (head) register plus a skid register. The state is EMPTY, ONE or TWO.
- EMPTY: on accept go to ONE and load main.
- ONE: on accept without drain go to TWO and load skid. On drain without accept go to EMPTY. On accept and drain together stay in ONE and reload main with the new entry.
- TWO: on drain go to ONE and move skid into main. No accept is possible in TWO.
- in_ready = (state != TWO) & !reset. It is decoded from the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data, out_sel and out_err always reflect main.
- While out_valid & !out_ready, out_data, out_sel and out_err stay bit-stable.
- Order is preserved. The skid entry is never emitted before main.
- flush has priority over accept and drain in the same cycle. The next state is EMPTY and the offered entry is dropped.

## Timing
- Reset, one cycle, synchronous:
  - next cycle: state EMPTY, out_valid 0, out_data RESET_VAL, out_sel 0, out_err 0;
  - in_ready is 0 during every cycle reset is high and 1 in the first cycle after.
- Reset mid-operation discards both entries. There is no partial drain.
- Latency: an entry accepted at edge n is visible on out_* with out_valid=1 after edge n (1 cycle).
- Throughput: 1 entry per cycle while out_ready=1. in_ready stays 1 in steady state.
- Backpressure: with out_ready low, the stage absorbs at most 2 entries. in_ready drops in the cycle after the second accept.
- Recovery: the first drain from TWO raises in_ready in the next cycle.
- flush: out_valid is 0 and in_ready is 1 in the cycle after flush.

## Test plan
- Reset check. Hold reset 3 cycles with in_valid=1 → out_valid=0, out_data=RESET_VAL and in_ready=0 throughout. in_ready=1 in the first cycle after reset deasserts.
- Select sweep (WIDTH=32, N_IN=4). Inputs are 0x11111111, 0x22222222, 0x33333333, 0x44444444. Drive sel=0..3 on consecutive cycles with out_ready=1 → out_data follows one cycle later in the same order, out_sel=0..3, and in_ready stays 1.
- Backpressure. Set out_ready=0 and offer 3 entries with sel=2,1,0 → first two accepted, in_ready=0, out_data=0x33333333 held stable. Release out_ready → outputs 0x33333333 then 0x22222222, then the third entry (0x11111111) is accepted and delivered.
- Simultaneous accept and drain in ONE. Stream sel=1,3 with out_ready=1 → state stays ONE and out_data=0x22222222 then 0x44444444 on consecutive cycles.
- Flush. Fill to TWO, then assert flush with in_valid=1 and out_ready=1 in the same cycle → next cycle out_valid=0 and in_ready=1. Neither the buffered entries nor the offered entry ever appears.
- Out-of-range select (N_IN=3, SEL_W=2). Send sel=3 → out_err=1, out_data=RESET_VAL, out_sel=3. The next entry with sel=0 gives out_err=0.
